// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state and operation encodings for the MULT/DIV sequencer.
package mult_div_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
    // bit 0 selects divide, bit 1 selects unsigned operands
    typedef enum logic [1:0] {OP_MULT = 2'd0, OP_DIV = 2'd1, OP_MULTU = 2'd2, OP_DIVU = 2'd3} op_t;
endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one combinational iteration, Booth/shift-add multiply or restoring divide.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic             uns,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_n,
    output logic [WIDTH-1:0] q_n,
    output logic             q1_n
);
    logic [WIDTH:0] sum, sh;
    logic lt;
    // unsigned multiply is plain shift-add; signed uses the Booth pair {q[0], q1}
    assign sum = uns ? (q[0] ? acc + m : acc)
               : ({q[0], q1} == 2'b01) ? acc + m
               : ({q[0], q1} == 2'b10) ? acc - m : acc;
    assign sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign lt = sh < m;
    assign acc_n = div ? (lt ? sh : sh - m) : {~uns & sum[WIDTH], sum[WIDTH:1]};
    assign q_n = div ? {q[WIDTH-2:0], ~lt} : {sum[0], q[WIDTH-1:1]};
    assign q1_n = ~div & q[0];
endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: 32-step MULT/DIV sequencer writing HI/LO.
// MULT_DIV_UNSIGNED_EN adds start_multu/start_divu for unsigned operation.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             start_multu,
    input  logic             start_divu,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t state, nxt;
    op_t op, op_sel;
    logic smu, sdu, go, sgn, dz, neg_q, neg_r, q1, q1_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0] acc, acc_n, m;
    logic [WIDTH-1:0] q, q_n, abs_a, abs_b, rem, quo;
`ifdef MULT_DIV_UNSIGNED_EN
    assign smu = start_multu;
    assign sdu = start_divu;
`else
    assign smu = 1'b0;
    assign sdu = 1'b0;
`endif
    assign go = start_mult | smu | start_div | sdu;
    assign op_sel = start_mult ? OP_MULT : smu ? OP_MULTU : start_div ? OP_DIV : OP_DIVU;
    assign sgn = ~op_sel[1];
    assign abs_a = (sgn & A[WIDTH-1]) ? -A : A;
    assign abs_b = (sgn & B[WIDTH-1]) ? -B : B;
    assign busy = (state == MULT) || (state == DIV);
    assign done = state == DONE;
    assign rem = acc_n[WIDTH-1:0];
    assign quo = q_n;
    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .div(op[0]), .uns(op[1]), .acc(acc), .q(q), .q1(q1), .m(m),
        .acc_n(acc_n), .q_n(q_n), .q1_n(q1_n)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (go) nxt = op_sel[0] ? DIV : MULT;
            MULT: if (cnt == LAST) nxt = DONE;
            DIV:  if (dz || cnt == LAST) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op <= OP_MULT;
            cnt <= '0;
            acc <= '0;
            q <= '0;
            q1 <= 1'b0;
            m <= '0;
            dz <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div_zero <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else if (state == IDLE && go) begin
            op <= op_sel;
            cnt <= '0;
            acc <= '0;
            q1 <= 1'b0;
            q <= op_sel[0] ? abs_a : A;
            m <= op_sel[0] ? {1'b0, abs_b} : {sgn & B[WIDTH-1], B};
            dz <= op_sel[0] && B == '0;
            neg_q <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r <= sgn & A[WIDTH-1];
            div_zero <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            acc <= acc_n;
            q <= q_n;
            q1 <= q1_n;
            // divide results are magnitudes until the sign fix-up here
            if (nxt == DONE && dz) div_zero <= 1'b1;
            else if (nxt == DONE && op[0]) begin
                hi <= neg_r ? -rem : rem;
                lo <= neg_q ? -quo : quo;
            end else if (nxt == DONE) begin
                hi <= rem;
                lo <= q_n;
            end
        end
    end
endmodule
